// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit frame path.
// Holds the scheduler state encoding and parameter sanity helpers.
package tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        PAYLOAD,
        PAD
    } tx_sched_state_t;

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h0000_D391;

    // Frames must stay dibit aligned through preamble and sync.
    function automatic bit sched_params_ok(int pre_len, int sync_len);
        return (pre_len >= 2) && (pre_len % 2 == 0) &&
               (sync_len >= 2) && (sync_len <= 32) &&
               (sync_len % 2 == 0);
    endfunction

endpackage

// File: rtl/tx_frame_scheduler.sv
// Serialises preamble, sync word, gated payload and a parity pad bit
// into the 1-bit stream feeding the bit-to-dibit width converter.
module tx_frame_scheduler
    import tx_pkg::*;
#(
    parameter int          PREAMBLE_LEN = 32,
    parameter int          SYNC_LEN     = 16,
    parameter logic [31:0] SYNC_WORD    = DEFAULT_SYNC_WORD,
    parameter int          LEN_W        = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic pl_valid,
    input  logic pl_data,
    input  logic pl_last,
    output logic pl_ready,
    output logic out_valid,
    output logic out_data,
    input  logic out_ready,
    output logic busy,
    output logic frame_done,
    output logic len_err
);

    localparam int IDX_MAX = (PREAMBLE_LEN > SYNC_LEN) ? PREAMBLE_LEN : SYNC_LEN;
    localparam int IDX_W   = $clog2(IDX_MAX);

    localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_LEN - 1);
    localparam logic [IDX_W-1:0] SYNC_LAST = IDX_W'(SYNC_LEN - 1);
    localparam logic [4:0]       SYNC_TOP  = 5'(SYNC_LEN - 1);
    localparam logic [LEN_W-1:0] CNT_LIM   = {{(LEN_W-1){1'b1}}, 1'b0};

    if (!sched_params_ok(PREAMBLE_LEN, SYNC_LEN)) begin : g_param_err
        $error("tx_frame_scheduler: PREAMBLE_LEN/SYNC_LEN must be even, >=2, SYNC_LEN<=32");
    end

    tx_sched_state_t  state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_data_q, out_data_d;
    logic             frame_done_q, frame_done_d;
    logic             len_err_q, len_err_d;

    logic       load;
    logic       forced;
    logic [4:0] sync_bit;

    assign load     = ~out_valid_q | out_ready;
    assign sync_bit = SYNC_TOP - 5'(idx_q);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        out_valid_d  = load ? 1'b0 : out_valid_q;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;
        len_err_d    = 1'b0;
        pl_ready     = 1'b0;
        forced       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pl_valid) begin
                    state_d = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (load) begin
                    out_valid_d = 1'b1;
                    out_data_d  = ~idx_q[0];
                    if (idx_q == PRE_LAST) begin
                        idx_d   = '0;
                        state_d = SYNC;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            SYNC: begin
                if (load) begin
                    out_valid_d = 1'b1;
                    out_data_d  = SYNC_WORD[sync_bit];
                    if (idx_q == SYNC_LAST) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = PAYLOAD;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PAYLOAD: begin
                pl_ready = load;
                if (load && pl_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pl_data;
                    cnt_d       = cnt_q + LEN_W'(1);
                    forced      = (cnt_q == CNT_LIM);
                    if (pl_last || forced) begin
                        len_err_d = forced & ~pl_last;
                        // Even count before this bit means an odd total.
                        if (!cnt_q[0]) begin
                            state_d = PAD;
                        end else begin
                            state_d      = IDLE;
                            frame_done_d = 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                if (load) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = 1'b0;
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 1'b0;
            frame_done_q <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
            len_err_q    <= len_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;
    assign len_err    = len_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed and randomized checks of tx_frame_scheduler against a
// frame-level reference model of the expected bit stream.
module tb_tx_frame_scheduler;

    localparam int LW  = 4;
    localparam int PRE = 32;
    localparam int SL  = 16;
    localparam int MAXP = (1 << LW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic pl_valid, pl_data, pl_last, pl_ready;
    logic out_valid, out_data, out_ready;
    logic busy, frame_done, len_err;

    always #5 clk = ~clk;

    tx_frame_scheduler #(.LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .pl_valid(pl_valid), .pl_data(pl_data), .pl_last(pl_last),
        .pl_ready(pl_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done), .len_err(len_err)
    );

    int ncomp = 0;
    int nfail = 0;
    int cyc = 0;
    bit rand_ready = 0;
    bit tmo = 0;

    bit exp_q[$];
    bit got_q[$];
    int got_cyc[$];
    int fd_cyc[$];
    bit pb_q[$];
    bit pl_q[$];
    int exp_fd, exp_le, n_le, stab_bad, rdy_bad;
    bit prev_stall, prev_data;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            prev_stall = 0;
        end else begin
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_cyc.push_back(cyc);
            end
            if (frame_done) fd_cyc.push_back(cyc);
            if (len_err) n_le++;
            if (prev_stall && !(out_valid === 1'b1 && out_data === prev_data))
                stab_bad++;
            if (pl_ready && !(busy && (!out_valid || out_ready)))
                rdy_bad++;
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        exp_q.delete(); got_q.delete(); got_cyc.delete(); fd_cyc.delete();
        pb_q.delete(); pl_q.delete();
        exp_fd = 0; exp_le = 0; n_le = 0; stab_bad = 0; rdy_bad = 0;
        tmo = 0;
    endtask

    // Reference: each upstream frame is cut into chunks of at most MAXP bits;
    // every chunk becomes preamble + sync + chunk (+ zero if odd).
    task automatic add_frame(input int len, input logic [31:0] bits);
        logic [31:0] sw;
        bit chunk[$];
        bit b, last;
        sw = 32'h0000_D391;
        for (int i = 0; i < len; i++) begin
            b = bits[len-1-i];
            last = (i == len - 1);
            pb_q.push_back(b);
            pl_q.push_back(last);
            chunk.push_back(b);
            if (last || chunk.size() == MAXP) begin
                for (int p = 0; p < PRE; p++) exp_q.push_back(p % 2 == 0);
                for (int s = 0; s < SL; s++) exp_q.push_back(sw[SL-1-s]);
                foreach (chunk[k]) exp_q.push_back(chunk[k]);
                if (chunk.size() % 2 == 1) exp_q.push_back(1'b0);
                exp_fd++;
                if (!last) exp_le++;
                chunk.delete();
            end
        end
    endtask

    task automatic drive(input bit gaps);
        int budget;
        while (pb_q.size() > 0 && !tmo) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                pl_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            pl_valid = 1'b1;
            pl_data  = pb_q.pop_front();
            pl_last  = pl_q.pop_front();
            budget = 0;
            forever begin
                @(negedge clk);
                if (pl_ready) break;
                budget++;
                if (budget > 3000) begin
                    tmo = 1;
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        pl_valid = 1'b0;
        pl_last  = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (got_q.size() < exp_q.size() && b < 5000) begin
            @(posedge clk);
            b++;
        end
        if (b >= 5000) tmo = 1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag);
        int mism = 0;
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) mism++;
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        chk({tag, "_bits"}, mism, 0);
        chk({tag, "_frames"}, fd_cyc.size(), exp_fd);
        chk({tag, "_lenerr"}, n_le, exp_le);
        chk({tag, "_timeout"}, 32'(tmo), 0);
    endtask

    initial begin
        int n1;
        int b;
        rst = 1'b0;
        pl_valid = 1'b0;
        pl_data = 1'b0;
        pl_last = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_pl_ready", 32'(pl_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_len_err", 32'(len_err), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        clear_all();
        add_frame(4, 32'b1101);
        drive(0);
        drain();
        check_stream("t1");
        chk("t1_total", got_q.size(), 52);

        clear_all();
        add_frame(3, 32'b011);
        drive(0);
        drain();
        check_stream("t2");
        chk("t2_total", got_q.size(), 52);
        chk("t2_done_at_pad",
            fd_cyc.size() > 0 ? fd_cyc[0] : -1,
            got_cyc.size() > 0 ? got_cyc[got_cyc.size()-1] : -2);

        clear_all();
        rand_ready = 1;
        for (int f = 0; f < 6; f++)
            add_frame($urandom_range(1, 14), $urandom);
        drive(1);
        drain();
        check_stream("t3");
        chk("t3_stable", stab_bad, 0);
        chk("t3_ready", rdy_bad, 0);
        rand_ready = 0;
        repeat (3) @(posedge clk);
        #1;

        clear_all();
        add_frame(20, $urandom);
        drive(0);
        drain();
        check_stream("t4");
        chk("t4_lenerr_once", n_le, 1);
        chk("t4_two_frames", fd_cyc.size(), 2);

        clear_all();
        pl_valid = 1'b1;
        pl_data  = 1'b1;
        b = 0;
        while (got_q.size() < 40 && b < 500) begin
            @(negedge clk);
            b++;
        end
        chk("t5_reach_sync", 32'(b >= 500), 0);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rst_outputs",
            {26'd0, out_valid, out_data, pl_ready, busy, frame_done, len_err}, 0);
        pl_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_all();
        @(posedge clk);
        #1;
        add_frame(2, $urandom);
        drive(0);
        drain();
        check_stream("t5");

        clear_all();
        add_frame(3, $urandom);
        n1 = exp_q.size();
        add_frame(5, $urandom);
        drive(0);
        drain();
        check_stream("t6");
        chk("t6_gap",
            (got_cyc.size() > n1 && fd_cyc.size() > 0) ?
                got_cyc[n1] - fd_cyc[0] : -1,
            2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
